// File: rtl/cpu_pkg.sv
// Shared datapath sizing for the CPU blocks; the register file takes its
// parameter defaults from here so every stage agrees on widths.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREG_DEF   = 2 ** ADDR_W_DEF;

    // Register 0 is hard-wired to zero throughout the datapath.
    localparam int ZERO_REG = 0;

endpackage : cpu_pkg

// File: rtl/reg_array.sv
// Register storage: one synchronous write port, two combinational read ports,
// synchronous clear. No bypass here; that lives in writeback_regfile.
module reg_array
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [NREG];

    // NOTE: this array is cleared by reset on purpose (reads must return 0 right
    // after reset), so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && int'(waddr) < NREG && int'(waddr) != ZERO_REG) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses beyond NREG-1 read as zero.
    assign rdata_a = (int'(raddr_a) < NREG) ? mem[raddr_a] : '0;
    assign rdata_b = (int'(raddr_b) < NREG) ? mem[raddr_b] : '0;

endmodule : reg_array

// File: rtl/writeback_regfile.sv
// Writeback pipeline register in front of the register array, with
// WB-to-read bypass so reads always see the youngest pending value.
module writeback_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Bus_D,
    input  logic [ADDR_W-1:0] DA,
    input  logic              RW,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    output logic [DATA_W-1:0] A_data,
    output logic [DATA_W-1:0] B_data,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] arr_a;
    logic [DATA_W-1:0] arr_b;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (!stall) begin
            wb_valid <= RW && (int'(DA) != ZERO_REG);
            wb_addr  <= DA;
            wb_data  <= Bus_D;
        end
    end

    // The entry already in WB commits even while stalled or flushed.
    reg_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_valid),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (AA),
        .raddr_b (BA),
        .rdata_a (arr_a),
        .rdata_b (arr_b)
    );

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] arr
    );
        if (int'(ra) == ZERO_REG || int'(ra) >= NREG) begin
            return '0;
        end else if (wb_valid && wb_addr == ra) begin
            return wb_data;
        end
        return arr;
    endfunction

    // NOTE: each output is assigned on every path through the block, so no
    // latch is inferred.
    always_comb begin
        A_data = read_port(AA, arr_a);
        B_data = read_port(BA, arr_b);
    end

endmodule : writeback_regfile

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: write/bypass, R0, back-to-back,
// stall/flush and mid-operation reset, with hand-computed expectations.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Bus_D;
    logic [4:0]  DA;
    logic        RW;
    logic        stall;
    logic        flush;
    logic [4:0]  AA;
    logic [4:0]  BA;
    logic [31:0] A_data;
    logic [31:0] B_data;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;

    writeback_regfile dut (
        .clk      (clk),
        .reset    (reset),
        .Bus_D    (Bus_D),
        .DA       (DA),
        .RW       (RW),
        .stall    (stall),
        .flush    (flush),
        .AA       (AA),
        .BA       (BA),
        .A_data   (A_data),
        .B_data   (B_data),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read(input logic [4:0] a, input logic [4:0] b);
        AA = a;
        BA = b;
        #1;
    endtask

    logic [31:0] fill_vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    initial begin
        reset = 1'b1;
        Bus_D = '0;
        DA    = '0;
        RW    = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        AA    = '0;
        BA    = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        read(5'd3, 5'd31);
        check("rst_read_a3", A_data, 32'd0);
        check("rst_read_b31", B_data, 32'd0);

        // Basic write with bypass, then from the array
        RW = 1'b1; DA = 5'd3; Bus_D = 32'hDEADBEEF;
        read(5'd3, 5'd3);
        tick();
        check("bw_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("bw_bypass_a", A_data, 32'hDEADBEEF);
        check("bw_bypass_b", B_data, 32'hDEADBEEF);
        RW = 1'b0; Bus_D = '0;
        tick();
        check("bw_valid_clr", {31'd0, wb_valid}, 32'd0);
        check("bw_array_a", A_data, 32'hDEADBEEF);
        check("bw_array_b", B_data, 32'hDEADBEEF);

        // R0 protection
        RW = 1'b1; DA = 5'd0; Bus_D = 32'hFFFFFFFF;
        read(5'd0, 5'd0);
        check("r0_pre_a", A_data, 32'd0);
        tick();
        check("r0_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("r0_cap_a", A_data, 32'd0);
        check("r0_cap_b", B_data, 32'd0);
        RW = 1'b0;
        tick();
        check("r0_post_a", A_data, 32'd0);
        check("r0_post_b", B_data, 32'd0);

        // Back-to-back writes to reg5
        RW = 1'b1; DA = 5'd5;
        read(5'd5, 5'd5);
        for (int i = 1; i <= 3; i++) begin
            Bus_D = 32'(i);
            tick();
            check($sformatf("b2b_a_%0d", i), A_data, 32'(i));
            check($sformatf("b2b_b_%0d", i), B_data, 32'(i));
        end
        RW = 1'b0; Bus_D = '0;
        tick();
        check("b2b_valid_clr", {31'd0, wb_valid}, 32'd0);
        check("b2b_final", A_data, 32'd3);

        // Stall then flush
        RW = 1'b1; DA = 5'd7; Bus_D = 32'h55;
        read(5'd7, 5'd7);
        tick();
        check("sf_cap_data", wb_data, 32'h55);
        stall = 1'b1; Bus_D = 32'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("sf_stall_data_%0d", i), wb_data, 32'h55);
            check($sformatf("sf_stall_valid_%0d", i), {31'd0, wb_valid}, 32'd1);
            check($sformatf("sf_stall_read_%0d", i), A_data, 32'h55);
        end
        stall = 1'b0; flush = 1'b1;
        tick();
        check("sf_flush_valid", {31'd0, wb_valid}, 32'd0);
        check("sf_flush_data", wb_data, 32'h55);
        check("sf_flush_read", A_data, 32'h55);
        flush = 1'b0; RW = 1'b0; Bus_D = '0;
        tick();
        check("sf_after_read", B_data, 32'h55);

        // Fill reg1..reg4, then reset on the commit edge of a reg9 write
        RW = 1'b1;
        for (int i = 0; i < 4; i++) begin
            DA = 5'(i + 1);
            Bus_D = fill_vals[i];
            tick();
        end
        RW = 1'b0; Bus_D = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            read(5'(i + 1), 5'(i + 1));
            check($sformatf("fill_a_%0d", i + 1), A_data, fill_vals[i]);
        end
        RW = 1'b1; DA = 5'd9; Bus_D = 32'h1234;
        tick();
        check("mid_cap_valid", {31'd0, wb_valid}, 32'd1);
        RW = 1'b0; Bus_D = '0; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("mid_wb_data", wb_data, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            read(5'(i), 5'(i));
            check($sformatf("mid_read_a_%0d", i), A_data, 32'd0);
            check($sformatf("mid_read_b_%0d", i), B_data, 32'd0);
        end
        read(5'd9, 5'd9);
        check("mid_reg9_a", A_data, 32'd0);
        tick();
        check("mid_reg9_late", B_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_writeback_regfile
